mux_rr_arbiter: RTL
===================

Name: mux_rr_arbiter

Overview:
- Shares one N:1 data mux between N_REQ requesters using a round-robin grant.
- Each requester presents data with a valid/ready handshake. The block drives the mux select and registers the selected word into a single output stage, which also has a valid/ready handshake.
- Sits in front of the 2x1/Nx1 mux datapath and acts as its sequencer. The mux select is never driven directly by requesters.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- DATA_W, 8, data width per requester.
- SEL_W, $clog2(N_REQ) (min 1), select/index width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  N_REQ  per-requester request/data valid.
- in_data  in  N_REQ*DATA_W  packed request data; requester i occupies bits [i*DATA_W +: DATA_W].
- in_ready  out  N_REQ  one-hot (or zero) accept strobe back to requesters.
- sel  out  SEL_W  mux select = index of the current winner.
- gnt  out  N_REQ  one-hot grant for the current cycle (zero when no request).
- out_valid  out  1  output register holds a word.
- out_data  out  DATA_W  registered muxed word.
- out_src  out  SEL_W  index of the requester that supplied out_data.
- out_ready  in  1  downstream accept.

Behaviour:
- Reset (rst=1 at posedge):
  - out_valid=0, out_data=0, out_src=0.
  - RR pointer=0; state=EMPTY.
  - gnt, in_ready and sel are combinational. They evaluate to 0 during reset because they are qualified by !rst.
- States:
  - EMPTY: output register empty.
  - FULL: out_valid=1.
- Winner selection (combinational):
  - Scan in_valid starting at ptr, then ptr+1, and so on, wrapping modulo N_REQ. The first set bit wins.
  - No valid input gives gnt=0 and sel holding its last-winner value (registered copy).
- can_load = (state==EMPTY) | (state==FULL & out_ready).
- in_ready[i] = gnt[i] & can_load & !rst. Exactly one requester is accepted per cycle, at most.
- Load on in_ready[w] & in_valid[w]:
  - out_data <= in_data[w], out_src <= w, out_valid <= 1.
  - state <= FULL.
  - ptr <= (w+1) mod N_REQ.
- Drain without load (FULL & out_ready & no winner): out_valid <= 0, state <= EMPTY; ptr unchanged.
- FULL & !out_ready: all outputs hold; in_ready=0 (backpressure). out_data is stable while out_valid=1 and out_ready=0.
- Latency and throughput:
  - Accepted input appears on out_valid/out_data at the next edge (1 cycle).
  - Sustains one transfer per cycle while out_ready=1.
- Simultaneous drain + load in the same cycle: the register is overwritten with the new word and out_valid stays 1 (no bubble).
- Fairness: a continuously requesting requester waits at most N_REQ-1 transfers.
- Wrap-around: ptr at N_REQ-1 goes to 0. For non-power-of-2 N_REQ, indices >= N_REQ are never selected.
- Reset asserted mid-transfer: any held word is discarded, with no handshake completion reported. The pointer returns to 0.
- A requester dropping in_valid before its grant loses nothing. The grant recomputes every cycle until a transfer is accepted.

Optional Feature:
- Macro: MUX_RR_ARBITER_LOCK_EN.
- Defined:
  - Adds an input port in_lock [N_REQ].
  - If the accepted requester w has in_lock[w]=1 at acceptance, ptr <= w instead of w+1, so w keeps top priority for the next transfer (burst).
  - A lock chain longer than 4 consecutive transfers is forcibly broken: the 5th accepted transfer advances ptr normally. A 3-bit burst counter implements this and resets on rst or on a non-locked acceptance.
- Undefined: no in_lock port and pure round-robin.

Decomposition:
- Package mux_arb_pkg:
  - State encoding constants ST_EMPTY=1'b0, ST_FULL=1'b1.
  - MAX_LOCK_BURST=4.
  - Helper function for SEL_W (clog2 with min 1).
- Sub-module rr_pick: purely combinational rotate-priority picker.
  - Inputs: req[N_REQ], ptr[SEL_W].
  - Outputs: gnt one-hot, idx, any.
  - Reusable by other arbiters.
- The top holds the pointer, output register, state and lock counter.

Test Plan:
- Reset: hold rst 2 cycles with in_valid=2'b11 -> in_ready=0, gnt=0, out_valid=0, out_data=0. The first post-reset transfer comes from requester 0.
- Alternation: N_REQ=2, in_valid=2'b11 constant, in_data0=8'hA1, in_data1=8'hB2, out_ready=1 -> out_src sequence 0,1,0,1. out_data is A1,B2,A1,B2 at one word per cycle, starting 1 cycle after the first accept.
- Single requester: only in_valid[1]=1, data 8'h5C -> sel=1, in_ready=2'b10. out_data=5C the next cycle. Requester 0 later requesting wins next (ptr wrapped to 0).
- Backpressure: load 8'h33, then out_ready=0 for 3 cycles with both requesting -> out_valid=1, out_data=33 stable, in_ready=0. On out_ready=1, the next word loads with no bubble.
- Reset mid-operation: out_valid=1 holding 8'h77, out_ready=0, assert rst -> next cycle out_valid=0, ptr=0.
- With MUX_RR_ARBITER_LOCK_EN: requester 0 holds in_lock=1, both requesting, out_ready=1 -> out_src 0,0,0,0 then 1 (burst break at 5th), then 0 resumes.

Source files
------------

// File: rtl/mux_rr_arbiter_pkg.sv
// Shared definitions for the round-robin mux arbiter: state encoding,
// lock-burst limit and the select-width helper.
package mux_arb_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } arb_state_e;

  localparam int MAX_LOCK_BURST = 4;

  // Index width for n entries; never narrower than one bit.
  function automatic int sel_w_f(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_pick.sv
// Combinational rotate-priority picker: first set request at or after ptr,
// wrapping modulo N_REQ. Usable by any round-robin arbiter.
module rr_pick
  import mux_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  localparam int SEL_W = sel_w_f(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] idx,
  output logic             any
);

  logic [SEL_W-1:0] w_cand;

  always_comb begin
    gnt    = '0;
    idx    = '0;
    any    = 1'b0;
    w_cand = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_cand = SEL_W'((int'(ptr) + k) % N_REQ);
      if (!any && req[w_cand]) begin
        any         = 1'b1;
        gnt[w_cand] = 1'b1;
        idx         = w_cand;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin sequencer for a shared N:1 mux with a one-word registered output.
// Optional burst locking is enabled with `define MUX_RR_ARBITER_LOCK_EN.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int DATA_W = 8,
  localparam int SEL_W = sel_w_f(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        in_valid,
  input  logic [N_REQ*DATA_W-1:0] in_data,
`ifdef MUX_RR_ARBITER_LOCK_EN
  input  logic [N_REQ-1:0]        in_lock,
`endif
  output logic [N_REQ-1:0]        in_ready,
  output logic [SEL_W-1:0]        sel,
  output logic [N_REQ-1:0]        gnt,
  output logic                    out_valid,
  output logic [DATA_W-1:0]       out_data,
  output logic [SEL_W-1:0]        out_src,
  input  logic                    out_ready
);

  arb_state_e        r_state, w_state_nxt;
  logic [SEL_W-1:0]  r_ptr, w_ptr_nxt;
  logic [SEL_W-1:0]  r_last_sel;
  logic [DATA_W-1:0] r_data_p1;
  logic [SEL_W-1:0]  r_src_p1;

  logic [N_REQ-1:0]  w_gnt;
  logic [SEL_W-1:0]  w_idx, w_idx_inc;
  logic              w_any, w_can_load, w_load;

`ifdef MUX_RR_ARBITER_LOCK_EN
  logic [2:0]        r_burst, w_burst_nxt;
`endif

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req (in_valid),
    .ptr (r_ptr),
    .gnt (w_gnt),
    .idx (w_idx),
    .any (w_any)
  );

  assign w_can_load = (r_state == ST_EMPTY) || out_ready;
  assign w_load     = w_any && w_can_load && !rst;
  assign w_idx_inc  = (w_idx == SEL_W'(N_REQ - 1)) ? '0 : w_idx + 1'b1;

  assign gnt       = rst ? '0 : w_gnt;
  assign in_ready  = w_gnt & {N_REQ{w_can_load && !rst}};
  assign sel       = rst ? '0 : (w_any ? w_idx : r_last_sel);
  assign out_valid = (r_state == ST_FULL);
  assign out_data  = r_data_p1;
  assign out_src   = r_src_p1;

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
`ifdef MUX_RR_ARBITER_LOCK_EN
    w_burst_nxt = r_burst;
`endif
    if (w_load) begin
      w_state_nxt = ST_FULL;
      w_ptr_nxt   = w_idx_inc;
`ifdef MUX_RR_ARBITER_LOCK_EN
      // Holding ptr re-grants w next; the chain is capped so that at most
      // MAX_LOCK_BURST consecutive transfers come from one locked requester.
      w_burst_nxt = '0;
      if (in_lock[w_idx] && (r_burst < 3'(MAX_LOCK_BURST - 1))) begin
        w_ptr_nxt   = w_idx;
        w_burst_nxt = r_burst + 3'd1;
      end
`endif
    end else if ((r_state == ST_FULL) && out_ready) begin
      w_state_nxt = ST_EMPTY;
    end
  end

  // ---- stage p1: output register and arbitration state ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_EMPTY;
      r_ptr      <= '0;
      r_last_sel <= '0;
      r_data_p1  <= '0;
      r_src_p1   <= '0;
`ifdef MUX_RR_ARBITER_LOCK_EN
      r_burst    <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
`ifdef MUX_RR_ARBITER_LOCK_EN
      r_burst <= w_burst_nxt;
`endif
      if (w_any) r_last_sel <= w_idx;
      if (w_load) begin
        r_data_p1 <= in_data[w_idx*DATA_W +: DATA_W];
        r_src_p1  <= w_idx;
      end
    end
  end

endmodule
